// File: rtl/shadow_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shadow_stack_pkg
// Brief    : OR1K call/return opcodes, monitor state and violation cause codes
// Revision : 1.0 - initial release
// ============================================================================
package shadow_stack_pkg;

    localparam logic [5:0] c_OP_JAL   = 6'h01;
    localparam logic [5:0] c_OP_JALR  = 6'h12;
    localparam logic [5:0] c_OP_JR    = 6'h11;
    localparam logic [4:0] c_LINK_REG = 5'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'b00,
        CAUSE_MISMATCH  = 2'b01,
        CAUSE_UNDERFLOW = 2'b10,
        CAUSE_OVERFLOW  = 2'b11
    } cause_t;

    function automatic logic is_call(input logic [31:0] insn);
        return (insn[31:26] == c_OP_JAL) || (insn[31:26] == c_OP_JALR);
    endfunction

    // Only l.jr through the link register counts as a return.
    function automatic logic is_return(input logic [31:0] insn);
        return (insn[31:26] == c_OP_JR) && (insn[15:11] == c_LINK_REG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shadow_stack_bank.sv
`default_nettype none
// ============================================================================
// Module   : shadow_stack_bank
// Brief    : NCTX independent circular return-address stacks, combinational TOS
// Revision : 1.0 - initial release
// ============================================================================
module shadow_stack_bank #(
    parameter  int AW    = 32,
    parameter  int DEPTH = 16,
    parameter  int NCTX  = 2,
    localparam int CTXW  = (NCTX > 1) ? $clog2(NCTX) : 1,
    localparam int PW    = $clog2(DEPTH),
    localparam int DW    = PW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [CTXW-1:0] i_ctx,
    input  logic [AW-1:0]   i_push_data,
    output logic [AW-1:0]   o_top,
    output logic [DW-1:0]   o_depth
);

    logic [NCTX-1:0][AW-1:0] w_top;
    logic [NCTX-1:0][DW-1:0] w_depth;

    for (genvar g = 0; g < NCTX; g++) begin : g_ctx
        logic [PW-1:0] r_ptr;
        logic [DW-1:0] r_depth;
        logic [AW-1:0] r_mem [DEPTH];
        logic          w_sel;

        assign w_sel = (i_ctx == CTXW'(g));

        // A push on a full stack advances the pointer over the oldest entry
        // while depth saturates; the caller decides whether that is allowed.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_ptr   <= '0;
                r_depth <= '0;
            end else if (w_sel) begin
                if (i_push) begin
                    r_ptr <= r_ptr + PW'(1);
                    if (r_depth != DW'(DEPTH)) begin
                        r_depth <= r_depth + DW'(1);
                    end
                end else if (i_pop) begin
                    r_ptr   <= r_ptr - PW'(1);
                    r_depth <= r_depth - DW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (w_sel && i_push) begin
                r_mem[r_ptr] <= i_push_data;
            end
        end

        assign w_top[g]   = r_mem[r_ptr - PW'(1)];
        assign w_depth[g] = r_depth;
    end

    always_comb begin
        o_top   = '0;
        o_depth = '0;
        for (int i = 0; i < NCTX; i++) begin
            if (i_ctx == CTXW'(i)) begin
                o_top   = w_top[i];
                o_depth = w_depth[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/shadow_stack_monitor_mp.sv
`default_nettype none
// ============================================================================
// Module   : shadow_stack_monitor_mp
// Brief    : Multi-context OR1K shadow-stack monitor with sticky violation flag
// Revision : 1.0 - initial release
// ============================================================================
module shadow_stack_monitor_mp
    import shadow_stack_pkg::*;
#(
    parameter  int AW       = 32,
    parameter  int DEPTH    = 16,
    parameter  int NCTX     = 2,
    parameter  int OVF_WRAP = 0,
    localparam int CTXW     = (NCTX > 1) ? $clog2(NCTX) : 1,
    localparam int DW       = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable_i,
    input  logic            int_en_i,
    input  logic            insn_valid_i,
    input  logic [31:0]     insn_i,
    input  logic [AW-1:0]   pc_i,
    input  logic [AW-1:0]   ret_target_i,
    input  logic [CTXW-1:0] ctx_i,
    input  logic            clear_i,
    output logic            stack_violation,
    output logic            interrupt,
    output logic [1:0]      viol_cause_o,
    output logic [CTXW-1:0] viol_ctx_o,
    output logic [2:0]      fsm_state
);

    localparam logic c_WRAP = (OVF_WRAP != 0);

    state_t          r_state;
    logic            r_viol;
    logic            r_irq;
    cause_t          r_cause;
    logic [CTXW-1:0] r_vctx;

    logic [AW-1:0]   w_top;
    logic [DW-1:0]   w_depth;
    logic            w_run;
    logic            w_is_call;
    logic            w_is_ret;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_viol;
    cause_t          w_cause;
    logic            w_unused_insn;

    assign w_unused_insn = ^{insn_i[25:16], insn_i[10:0]};

    assign w_run     = (r_state == ST_RUN);
    assign w_is_call = insn_valid_i && is_call(insn_i);
    assign w_is_ret  = insn_valid_i && is_return(insn_i);
    assign w_full    = (w_depth == DW'(DEPTH));
    assign w_empty   = (w_depth == '0);

    // Mismatching returns still pop so the stack tracks the consumed frame.
    assign w_push = w_run && w_is_call && (!w_full || c_WRAP);
    assign w_pop  = w_run && w_is_ret && !w_empty;

    always_comb begin
        w_cause = CAUSE_NONE;
        if (w_run && w_is_call && w_full && !c_WRAP) begin
            w_cause = CAUSE_OVERFLOW;
        end else if (w_run && w_is_ret && w_empty) begin
            w_cause = CAUSE_UNDERFLOW;
        end else if (w_run && w_is_ret && (w_top != ret_target_i)) begin
            w_cause = CAUSE_MISMATCH;
        end
    end

    assign w_viol = (w_cause != CAUSE_NONE);

    shadow_stack_bank #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .NCTX  (NCTX)
    ) u_bank (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_ctx       (ctx_i),
        .i_push_data (pc_i + AW'(8)),
        .o_top       (w_top),
        .o_depth     (w_depth)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_viol  <= 1'b0;
            r_irq   <= 1'b0;
            r_cause <= CAUSE_NONE;
            r_vctx  <= '0;
        end else begin
            r_irq <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable_i) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_viol) begin
                        r_state <= ST_HALT;
                        r_viol  <= 1'b1;
                        r_cause <= w_cause;
                        r_vctx  <= ctx_i;
                        r_irq   <= int_en_i;
                    end else if (!enable_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    if (clear_i) begin
                        r_state <= ST_RUN;
                        r_viol  <= 1'b0;
                        r_cause <= CAUSE_NONE;
                        r_vctx  <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stack_violation = r_viol;
    assign interrupt       = r_irq;
    assign viol_cause_o    = r_cause;
    assign viol_ctx_o      = r_vctx;
    assign fsm_state       = {1'b0, r_state};

endmodule
`default_nettype wire

// File: tb/tb_shadow_stack_monitor_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_shadow_stack_monitor_mp
// Brief    : Directed + random bench; one halting and one wrapping instance
// Revision : 1.0 - initial release
// ============================================================================
module tb_shadow_stack_monitor_mp;

    localparam int AW = 32;
    localparam int D  = 4;
    localparam int NC = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable_i = 1'b0;
    logic              int_en_i = 1'b0;
    logic              insn_valid_i = 1'b0;
    logic [31:0]       insn_i = '0;
    logic [AW-1:0]     pc_i = '0;
    logic [AW-1:0]     ret_target_i = '0;
    logic              ctx_i = 1'b0;
    logic              clear_i = 1'b0;

    logic [1:0]        sv;
    logic [1:0]        irq;
    logic [1:0][1:0]   cause;
    logic [1:0]        vctx;
    logic [1:0][2:0]   st;

    always #5 clk = ~clk;

    shadow_stack_monitor_mp #(.AW(AW), .DEPTH(D), .NCTX(NC), .OVF_WRAP(0)) dut0 (
        .clk(clk), .reset(reset), .enable_i(enable_i), .int_en_i(int_en_i),
        .insn_valid_i(insn_valid_i), .insn_i(insn_i), .pc_i(pc_i),
        .ret_target_i(ret_target_i), .ctx_i(ctx_i), .clear_i(clear_i),
        .stack_violation(sv[0]), .interrupt(irq[0]), .viol_cause_o(cause[0]),
        .viol_ctx_o(vctx[0]), .fsm_state(st[0])
    );

    shadow_stack_monitor_mp #(.AW(AW), .DEPTH(D), .NCTX(NC), .OVF_WRAP(1)) dut1 (
        .clk(clk), .reset(reset), .enable_i(enable_i), .int_en_i(int_en_i),
        .insn_valid_i(insn_valid_i), .insn_i(insn_i), .pc_i(pc_i),
        .ret_target_i(ret_target_i), .ctx_i(ctx_i), .clear_i(clear_i),
        .stack_violation(sv[1]), .interrupt(irq[1]), .viol_cause_o(cause[1]),
        .viol_ctx_o(vctx[1]), .fsm_state(st[1])
    );

    // Reference model: plain arrays used as stacks, index 0 = oldest.
    int            m_st    [2];
    bit            m_sv    [2];
    bit            m_irq   [2];
    int            m_cause [2];
    int            m_vctx  [2];
    logic [AW-1:0] m_stk   [2][NC][D];
    int            m_cnt   [2][NC];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_st[m] = 0; m_sv[m] = 0; m_irq[m] = 0; m_cause[m] = 0; m_vctx[m] = 0;
            for (int c = 0; c < NC; c++) m_cnt[m][c] = 0;
        end
    endtask

    task automatic model_step(input int m);
        bit call, ret;
        int c, x;
        call = insn_valid_i && (insn_i[31:26] == 6'h01 || insn_i[31:26] == 6'h12);
        ret  = insn_valid_i && insn_i[31:26] == 6'h11 && insn_i[15:11] == 5'd9;
        c = 0;
        x = int'(ctx_i);
        m_irq[m] = 0;
        case (m_st[m])
            0: if (enable_i) m_st[m] = 1;
            1: begin
                if (call) begin
                    if (m_cnt[m][x] == D) begin
                        if (m == 1) begin   // instance 1 drops the oldest frame
                            for (int k = 0; k < D - 1; k++) m_stk[m][x][k] = m_stk[m][x][k+1];
                            m_stk[m][x][D-1] = pc_i + 8;
                        end else begin
                            c = 3;
                        end
                    end else begin
                        m_stk[m][x][m_cnt[m][x]] = pc_i + 8;
                        m_cnt[m][x]++;
                    end
                end else if (ret) begin
                    if (m_cnt[m][x] == 0) begin
                        c = 2;
                    end else begin
                        m_cnt[m][x]--;
                        if (m_stk[m][x][m_cnt[m][x]] !== ret_target_i) c = 1;
                    end
                end
                if (c != 0) begin
                    m_st[m] = 2; m_sv[m] = 1; m_cause[m] = c; m_vctx[m] = x; m_irq[m] = int_en_i;
                end else if (!enable_i) begin
                    m_st[m] = 0;
                end
            end
            default: if (clear_i) begin
                m_st[m] = 1; m_sv[m] = 0; m_cause[m] = 0; m_vctx[m] = 0;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s.sv%0d", tag, m),    sv[m],    64'(m_sv[m]));
            chk($sformatf("%s.irq%0d", tag, m),   irq[m],   64'(m_irq[m]));
            chk($sformatf("%s.cause%0d", tag, m), cause[m], 64'(m_cause[m]));
            chk($sformatf("%s.vctx%0d", tag, m),  vctx[m],  64'(m_vctx[m]));
            chk($sformatf("%s.state%0d", tag, m), st[m],    64'(m_st[m]));
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!reset) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
        #1;
        check_all(tag);
    endtask

    task automatic drive(input string tag, input logic [5:0] op, input logic [4:0] rb,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic cx);
        insn_valid_i = 1'b1;
        insn_i       = {op, 10'd0, rb, 11'd0};
        pc_i         = pc;
        ret_target_i = tgt;
        ctx_i        = cx;
        step(tag);
        insn_valid_i = 1'b0;
    endtask

    task automatic do_call(input string tag, input logic [31:0] pc, input logic cx);
        drive(tag, 6'h01, 5'd0, pc, 32'd0, cx);
    endtask

    task automatic do_ret(input string tag, input logic [31:0] tgt, input logic cx);
        drive(tag, 6'h11, 5'd9, 32'd0, tgt, cx);
    endtask

    task automatic do_clear(input string tag);
        clear_i = 1'b1;
        step(tag);
        clear_i = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        int          kind;
        int          x;

        model_reset();
        #1;
        chk("rst.sv", sv, 2'b00);
        chk("rst.state", st[0], 3'd0);
        step("rst");
        @(negedge clk) reset = 1'b1;
        enable_i = 1'b1;
        step("enable");
        chk("run.state", st[0], 3'd1);

        // Matched call/return, then a second return proves depth is back to 0.
        do_call("c100", 32'h100, 1'b0);
        do_ret("r108", 32'h108, 1'b0);
        chk("r108.sv", sv, 2'b00);
        do_ret("r_empty0", 32'h108, 1'b0);
        chk("empty0.cause", cause[0], 2'd2);
        do_clear("clr0");

        int_en_i = 1'b1;
        do_call("c200", 32'h200, 1'b0);
        do_ret("r300", 32'h300, 1'b0);
        chk("mm.cause", cause[0], 2'd1);
        chk("mm.irq", irq[0], 1'b1);
        chk("mm.state", st[0], 3'd2);
        step("mm.hold");
        chk("mm.irq_drop", irq[0], 1'b0);
        chk("mm.sticky", sv[0], 1'b1);
        int_en_i = 1'b0;
        do_clear("clr1");

        do_ret("r_empty1", 32'h0, 1'b1);
        chk("empty1.cause", cause[1], 2'd2);
        chk("empty1.vctx", vctx[1], 1'b1);
        do_clear("clr2");
        chk("clr2.state", st[1], 3'd1);
        chk("clr2.flags", {sv, cause[1]}, 4'd0);

        do_call("c400", 32'h400, 1'b0);
        do_call("c500", 32'h500, 1'b1);
        do_ret("r508", 32'h508, 1'b1);
        do_ret("r408", 32'h408, 1'b0);
        chk("ilv.sv", sv, 2'b00);

        for (int i = 0; i <= D; i++) do_call("ovf", 32'h1000 + 32'(i) * 32'h10, 1'b0);
        chk("ovf.cause0", cause[0], 2'd3);
        chk("ovf.sv1", sv[1], 1'b0);
        for (int k = 0; k < D; k++) do_ret("wrap_ret", 32'h1000 + 32'(D - k) * 32'h10 + 32'h8, 1'b0);
        chk("wrap.sv1", sv[1], 1'b0);
        do_clear("clr3");

        // Reset arrives one cycle after a mismatching return.
        do_call("c600", 32'h600, 1'b1);
        do_ret("r700", 32'h700, 1'b1);
        reset = 1'b0;
        #1;
        model_reset();
        chk("rstmid.sv", sv, 2'b00);
        chk("rstmid.state", st[1], 3'd0);
        step("rstmid");
        @(negedge clk) reset = 1'b1;
        step("resume");

        for (int i = 0; i < 400; i++) begin
            enable_i = ($urandom_range(0, 19) != 0);
            int_en_i = 1'($urandom);
            clear_i  = ($urandom_range(0, 3) == 0);
            ctx_i    = 1'($urandom);
            x        = int'(ctx_i);
            pc_i     = 32'($urandom_range(0, 1023)) << 2;
            r        = $urandom;
            kind     = $urandom_range(0, 9);
            insn_valid_i = (kind != 9);
            if (kind < 2)      r[31:26] = 6'h01;
            else if (kind < 4) r[31:26] = 6'h12;
            else if (kind < 8) r[31:26] = 6'h11;
            else               r[31:26] = 6'h05;
            if (kind == 7) r[15:11] = 5'd3;
            else if (kind >= 4 && kind < 7) r[15:11] = 5'd9;
            insn_i = r;
            if (m_cnt[0][x] > 0 && $urandom_range(0, 3) != 0)
                ret_target_i = m_stk[0][x][m_cnt[0][x] - 1];
            else
                ret_target_i = 32'($urandom_range(0, 1023)) << 2;
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
